config_loader: RTL and testbench

Configuration-bus initiator for the tile array. It accepts a byte stream of 8-byte configuration records under a valid/ready handshake. It assembles each record into a 32-bit address and 32-bit data word and drives them onto the shared `config_addr`/`config_data` bus that every tile decodes against its `tile_id`. Loading ends on a terminator record, after which the block reports completion and the number of writes issued.

---
 rtl/config_loader.sv | 160 ++++++++++++++++
 tb/tb_config_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// config_loader: configuration-bus initiator for the tile array.
// Assembles 8-byte records (4 address bytes, then 4 data bytes, MSB first)
// from a valid/ready byte stream. Each record is driven onto the shared
// config bus for HOLD_CYCLES cycles. A record whose address equals
// IDLE_ADDR terminates the load.
//
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous active-low reset
//   start        - one-cycle pulse, begins a load (honoured in IDLE/DONE)
//   in_valid     - stream byte present
//   in_data[7:0] - stream byte
//   in_ready     - byte accepted this cycle (decoded from state)
//   config_addr  - bus address, IDLE_ADDR when no write is active
//   config_data  - bus payload, 0 when no write is active
//   config_valid - write held on the bus
//   busy         - loading or writing
//   done         - terminator seen; sticky until start/reset
//   write_count  - writes issued in the current load (saturating)
module config_loader #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] write_count
);

  localparam int unsigned HOLD_W = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned REC_W  = 56;
  localparam int unsigned WC_W   = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(7);
  localparam logic [WC_W-1:0]   WC_MAX    = {WC_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [REC_W-1:0]  rec_q, rec_d;
  logic [31:0]       addr_d, data_d;
  logic [WC_W-1:0]   wc_d;
  logic              valid_d, busy_d, done_d;
  logic [63:0]       rec_full;

  // Complete record as it would stand once the current byte is shifted in.
  assign rec_full = {rec_q, in_data};

  assign in_ready = (state_q == S_LOAD);

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hold_d     = hold_q;
    rec_d      = rec_q;
    addr_d     = config_addr;
    data_d     = config_data;
    wc_d       = write_count;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          byte_cnt_d = '0;
          wc_d       = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          rec_d      = rec_full[REC_W-1:0];
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q == LAST_BYTE) begin
            // Terminator issues no write; its data bytes are discarded.
            if (rec_full[63:32] == IDLE_ADDR) begin
              state_d = S_DONE;
            end else begin
              state_d = S_WRITE;
              addr_d  = rec_full[63:32];
              data_d  = rec_full[31:0];
              hold_d  = '0;
            end
          end
        end
      end
      S_WRITE: begin
        if (hold_q == HOLD_LAST) begin
          state_d    = S_LOAD;
          hold_d     = '0;
          byte_cnt_d = '0;
          addr_d     = IDLE_ADDR;
          data_d     = '0;
          wc_d       = (write_count == WC_MAX) ? write_count : write_count + WC_W'(1);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = IDLE_ADDR;
        data_d  = '0;
      end
    endcase

    // Status outputs are registered copies of the next state.
    valid_d = (state_d == S_WRITE);
    busy_d  = (state_d == S_LOAD) || (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_q   <= '0;
      hold_q       <= '0;
      rec_q        <= '0;
      config_addr  <= IDLE_ADDR;
      config_data  <= '0;
      config_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      write_count  <= '0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      hold_q       <= hold_d;
      rec_q        <= rec_d;
      config_addr  <= addr_d;
      config_data  <= data_d;
      config_valid <= valid_d;
      busy         <= busy_d;
      done         <= done_d;
      write_count  <= wc_d;
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed testbench for config_loader with HOLD_CYCLES = 2.
module tb_config_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_valid;
  logic        busy;
  logic        done;
  logic [15:0] write_count;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  config_loader #(.HOLD_CYCLES(2), .IDLE_ADDR(32'hFFFF_FFFF)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .config_addr  (config_addr),
    .config_data  (config_data),
    .config_valid (config_valid),
    .busy         (busy),
    .done         (done),
    .write_count  (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Advance one edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Stream one 8-byte record, optionally idling in_valid every other cycle.
  task automatic stream_record(input logic [63:0] rec, input bit stall, output int cyc);
    int   idx;
    bit   phase;
    logic rdy;
    logic drove;
    idx = 0; phase = 1'b0; cyc = 0;
    while (idx < 8 && cyc < 100) begin
      rdy      = in_ready;
      drove    = !(stall && phase);
      in_valid = drove;
      in_data  = rec[8*(7-idx) +: 8];
      tick;
      cyc++;
      phase = ~phase;
      if (drove && rdy) idx++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 8) begin
      errors++;
      $display("FAIL stream_timeout: accepted %0d bytes, required 8", idx);
    end
  endtask

  // Observe one write window: number of valid cycles, bus values, stability.
  task automatic watch_write(output int vc, output logic [31:0] a, output logic [31:0] d,
                             output bit stable);
    vc = 0; stable = 1'b1; a = IDLE; d = '0;
    for (int k = 0; k < 20; k++) begin
      if (config_valid) begin
        if (vc == 0) begin
          a = config_addr;
          d = config_data;
        end else if (config_addr !== a || config_data !== d) begin
          stable = 1'b0;
        end
        vc++;
      end else if (vc > 0) begin
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      tick;
    end
    checks += 7;
    if (in_ready !== 1'b0)     begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (config_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", config_valid); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (done !== 1'b0)         begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    if (config_addr !== IDLE)  begin errors++; $display("FAIL rst_addr: got %h want %h", config_addr, IDLE); end
    if (config_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", config_data); end
    if (write_count !== 16'h0) begin errors++; $display("FAIL rst_wcount: got %h want 0", write_count); end
    start = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick;
    in_valid = 1'b0;
    checks += 2;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_write;
    int          cyc, vc;
    logic [31:0] a, d;
    bit          st;
    // A byte offered alongside start must not be consumed.
    start = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    tick;
    start = 1'b0; in_valid = 1'b0;
    checks += 3;
    if (busy !== 1'b1)         begin errors++; $display("FAIL sw_busy: got %b want 1", busy); end
    if (in_ready !== 1'b1)     begin errors++; $display("FAIL sw_in_ready: got %b want 1", in_ready); end
    if (write_count !== 16'h0) begin errors++; $display("FAIL sw_wcount0: got %h want 0", write_count); end
    stream_record(64'h0007_0003_DEAD_BEEF, 1'b0, cyc);
    checks += 3;
    if (cyc != 8)              begin errors++; $display("FAIL sw_cycles: got %0d want 8", cyc); end
    if (config_valid !== 1'b1) begin errors++; $display("FAIL sw_latency: valid %b want 1", config_valid); end
    if (in_ready !== 1'b0)     begin errors++; $display("FAIL sw_ready_wr: got %b want 0", in_ready); end
    watch_write(vc, a, d, st);
    checks += 4;
    if (vc != 2)              begin errors++; $display("FAIL sw_hold: got %0d cycles want 2", vc); end
    if (a !== 32'h0007_0003)  begin errors++; $display("FAIL sw_addr: got %h want 00070003", a); end
    if (d !== 32'hDEAD_BEEF)  begin errors++; $display("FAIL sw_data: got %h want deadbeef", d); end
    if (st !== 1'b1)          begin errors++; $display("FAIL sw_stable: bus changed during hold"); end
    checks += 4;
    if (config_addr !== IDLE)  begin errors++; $display("FAIL sw_idle_addr: got %h want %h", config_addr, IDLE); end
    if (config_data !== 32'h0) begin errors++; $display("FAIL sw_idle_data: got %h want 0", config_data); end
    if (write_count !== 16'h1) begin errors++; $display("FAIL sw_wcount: got %h want 1", write_count); end
    if (in_ready !== 1'b1)     begin errors++; $display("FAIL sw_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_terminator(input logic [15:0] exp_wc);
    int          cyc, vc;
    logic [31:0] a, d;
    bit          st;
    stream_record(64'hFFFF_FFFF_1234_5678, 1'b0, cyc);
    checks += 3;
    if (done !== 1'b1)         begin errors++; $display("FAIL term_done: got %b want 1", done); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL term_busy: got %b want 0", busy); end
    if (config_valid !== 1'b0) begin errors++; $display("FAIL term_valid: got %b want 0", config_valid); end
    watch_write(vc, a, d, st);
    checks += 5;
    if (vc != 0)               begin errors++; $display("FAIL term_nowrite: got %0d valid cycles want 0", vc); end
    if (write_count !== exp_wc) begin errors++; $display("FAIL term_wcount: got %h want %h", write_count, exp_wc); end
    if (in_ready !== 1'b0)     begin errors++; $display("FAIL term_ready: got %b want 0", in_ready); end
    if (config_addr !== IDLE)  begin errors++; $display("FAIL term_addr: got %h want %h", config_addr, IDLE); end
    if (done !== 1'b1)         begin errors++; $display("FAIL term_sticky: got %b want 1", done); end
  endtask

  task automatic test_stall;
    int          cyc, vc;
    logic [31:0] a, d;
    bit          st;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks += 2;
    if (done !== 1'b0)         begin errors++; $display("FAIL st_done_clr: got %b want 0", done); end
    if (write_count !== 16'h0) begin errors++; $display("FAIL st_wcount0: got %h want 0", write_count); end
    stream_record(64'h0007_0003_DEAD_BEEF, 1'b1, cyc);
    checks++;
    if (cyc != 15) begin errors++; $display("FAIL st_cycles: got %0d want 15", cyc); end
    watch_write(vc, a, d, st);
    checks += 4;
    if (vc != 2)               begin errors++; $display("FAIL st_hold: got %0d want 2", vc); end
    if (a !== 32'h0007_0003)   begin errors++; $display("FAIL st_addr: got %h want 00070003", a); end
    if (d !== 32'hDEAD_BEEF)   begin errors++; $display("FAIL st_data: got %h want deadbeef", d); end
    if (write_count !== 16'h1) begin errors++; $display("FAIL st_wcount: got %h want 1", write_count); end
  endtask

  task automatic test_back_to_back;
    logic [191:0] all;
    logic [31:0]  exp_a [3];
    logic [31:0]  got_a [3];
    int           rise [3];
    int           idx, cyc, nw;
    logic         rdy, prev_v;
    bit           bad_idle;
    all = {64'h0001_0002_1111_1111, 64'h0003_0004_2222_2222, 64'h0005_0006_3333_3333};
    exp_a[0] = 32'h0001_0002; exp_a[1] = 32'h0003_0004; exp_a[2] = 32'h0005_0006;
    for (int i = 0; i < 3; i++) begin rise[i] = 0; got_a[i] = '0; end
    start = 1'b1;
    tick;
    start = 1'b0;
    idx = 0; cyc = 0; nw = 0; prev_v = 1'b0; bad_idle = 1'b0;
    while ((nw < 3 || config_valid) && cyc < 200) begin
      rdy      = in_ready;
      in_valid = (idx < 24);
      in_data  = (idx < 24) ? all[8*(23-idx) +: 8] : 8'h00;
      start    = (cyc == 3);  // ignored while loading
      tick;
      cyc++;
      if (in_valid && rdy) idx++;
      if (config_valid && !prev_v && nw < 3) begin
        rise[nw]  = cyc;
        got_a[nw] = config_addr;
        nw++;
      end
      if (!config_valid && config_addr !== IDLE) bad_idle = 1'b1;
      prev_v = config_valid;
    end
    in_valid = 1'b0; start = 1'b0;
    checks += 4;
    if (nw != 3)                begin errors++; $display("FAIL b2b_writes: got %0d want 3", nw); end
    if (rise[1] - rise[0] != 10) begin errors++; $display("FAIL b2b_gap1: got %0d want 10", rise[1] - rise[0]); end
    if (rise[2] - rise[1] != 10) begin errors++; $display("FAIL b2b_gap2: got %0d want 10", rise[2] - rise[1]); end
    if (bad_idle)               begin errors++; $display("FAIL b2b_idle_addr: bus not idle between writes"); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_a[i] !== exp_a[i]) begin errors++; $display("FAIL b2b_addr%0d: got %h want %h", i, got_a[i], exp_a[i]); end
    end
    checks++;
    if (write_count !== 16'h3) begin errors++; $display("FAIL b2b_wcount: got %h want 3", write_count); end
  endtask

  task automatic test_reset_mid_write;
    int          cyc, vc;
    logic [31:0] a, d;
    bit          st;
    stream_record(64'h0008_0009_CAFE_F00D, 1'b0, cyc);
    checks++;
    if (config_valid !== 1'b1) begin errors++; $display("FAIL rmw_pre: valid %b want 1", config_valid); end
    reset    = 1'b0;
    in_valid = 1'($urandom);
    in_data  = 8'($urandom);
    start    = 1'($urandom);
    #1;
    checks += 5;
    if (config_valid !== 1'b0) begin errors++; $display("FAIL rmw_valid: got %b want 0", config_valid); end
    if (config_addr !== IDLE)  begin errors++; $display("FAIL rmw_addr: got %h want %h", config_addr, IDLE); end
    if (config_data !== 32'h0) begin errors++; $display("FAIL rmw_data: got %h want 0", config_data); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL rmw_busy: got %b want 0", busy); end
    if (write_count !== 16'h0) begin errors++; $display("FAIL rmw_wcount: got %h want 0", write_count); end
    tick;
    // Release reset with start in the same cycle.
    reset = 1'b1; start = 1'b1; in_valid = 1'b0;
    tick;
    start = 1'b0;
    checks += 2;
    if (busy !== 1'b1)     begin errors++; $display("FAIL rmw_start_busy: got %b want 1", busy); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmw_start_ready: got %b want 1", in_ready); end
    stream_record(64'h000A_000B_1234_5678, 1'b0, cyc);
    watch_write(vc, a, d, st);
    checks += 4;
    if (vc != 2)               begin errors++; $display("FAIL rmw_hold: got %0d want 2", vc); end
    if (a !== 32'h000A_000B)   begin errors++; $display("FAIL rmw_new_addr: got %h want 000a000b", a); end
    if (d !== 32'h1234_5678)   begin errors++; $display("FAIL rmw_new_data: got %h want 12345678", d); end
    if (write_count !== 16'h1) begin errors++; $display("FAIL rmw_wcount1: got %h want 1", write_count); end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_terminator(16'h1);
    test_stall;
    test_terminator(16'h1);
    test_back_to_back;
    test_reset_mid_write;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
